// File: rtl/fifo_pkg.sv
// Constants and types shared by the per-lane FIFOs and the central flow-control controller.
package fifo_pkg;
  localparam int DATA_WIDTH   = 6;
  localparam int ADDR_WIDTH   = 3;
  localparam int DEPTH        = 1 << ADDR_WIDTH;
  localparam int UMBRAL_L_RST = 1;
  localparam int UMBRAL_H_RST = 7;

  typedef logic [3:0] thr_t;
endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DW two-port storage: synchronous write, registered read that holds when not enabled.
module fifo_mem_2p #(
  parameter int DW = 6,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdata_q;

  // Read sees the pre-write value when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_umbral_flags.sv
// Per-lane FIFO with programmable almost-empty/almost-full thresholds and a sticky error flag.
module fifo_umbral_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH,
  parameter int UMBRAL_L_RST = fifo_pkg::UMBRAL_L_RST,
  parameter int UMBRAL_H_RST = fifo_pkg::UMBRAL_H_RST
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  thr_t                  umbral_L,
  input  thr_t                  umbral_H,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int FW    = (CW > 4) ? CW : 4;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  thr_t                  thr_l_q, thr_h_q;
  logic                  err_q, vld_q, seen_q;
  logic                  push_ok, pop_ok, is_empty, is_full;
  logic [DATA_WIDTH-1:0] rdata;

  function automatic thr_t clamp(input thr_t u);
    return (FW'(u) > FW'(DEPTH)) ? thr_t'(DEPTH) : u;
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop_ok   = !init && pop && !is_empty;
  assign push_ok  = !init && push && (!is_full || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      thr_l_q  <= thr_t'(UMBRAL_L_RST);
      thr_h_q  <= thr_t'(UMBRAL_H_RST);
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      if (init) begin
        thr_l_q <= clamp(umbral_L);
        thr_h_q <= clamp(umbral_H);
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop_ok)  seen_q   <= 1'b1;
      count_q <= count_d;
      vld_q   <= pop_ok;
      // Overflow, or underflow (including the push+pop-on-empty case).
      if (!init && ((push && is_full && !pop_ok) || (pop && is_empty))) err_q <= 1'b1;
    end
  end

  fifo_mem_2p #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Storage has no reset, so data_out reads as zero until the first pop after reset.
  assign data_out     = seen_q ? rdata : '0;
  assign valid_out    = vld_q;
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = FW'(count_q) <= FW'(thr_l_q);
  assign almost_full  = FW'(count_q) >= FW'(thr_h_q);
  assign error        = err_q;
endmodule

// File: tb/tb_fifo_umbral_flags.sv
// Scoreboard bench for fifo_umbral_flags: reference queue model, read data checked one cycle after pop.
module tb_fifo_umbral_flags;
  import fifo_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_L, init, push, pop;
  thr_t                  umbral_L, umbral_H;
  logic [DATA_WIDTH-1:0] data_in, data_out;
  logic                  valid_out, empty, full, almost_empty, almost_full, error;
  logic [ADDR_WIDTH:0]   count;

  fifo_umbral_flags dut (
    .clk(clk), .reset_L(reset_L), .init(init), .umbral_L(umbral_L), .umbral_H(umbral_H),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [DATA_WIDTH-1:0] mdl[$];
  logic [DATA_WIDTH-1:0] sb[$];
  int thr_l, thr_h;
  bit m_err, m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int u);
    return (u > DEPTH) ? DEPTH : u;
  endfunction

  task automatic model_reset();
    mdl.delete();
    sb.delete();
    thr_l = UMBRAL_L_RST;
    thr_h = UMBRAL_H_RST;
    m_err = 1'b0;
    m_vld = 1'b0;
  endtask

  task automatic check_all(input string ph);
    int n;
    n = mdl.size();
    chk({ph, ".count"}, count, n);
    chk({ph, ".empty"}, empty, n == 0);
    chk({ph, ".full"}, full, n == DEPTH);
    chk({ph, ".aempty"}, almost_empty, n <= thr_l);
    chk({ph, ".afull"}, almost_full, n >= thr_h);
    chk({ph, ".error"}, error, m_err);
    chk({ph, ".valid"}, valid_out, m_vld);
    if (m_vld && sb.size() > 0) chk({ph, ".data"}, data_out, sb.pop_front());
  endtask

  // One clock: drive at negedge, update the model on posedge, check at the next negedge.
  task automatic cyc(input string ph, input bit i, input bit pu, input bit po,
                     input logic [DATA_WIDTH-1:0] d, input int ul = 0, input int uh = 0);
    bit pop_ok, was_full;
    init = i; push = pu; pop = po; data_in = d;
    umbral_L = thr_t'(ul); umbral_H = thr_t'(uh);
    @(posedge clk);
    if (i) begin
      thr_l = clampv(ul);
      thr_h = clampv(uh);
      m_vld = 1'b0;
    end else begin
      pop_ok   = po && mdl.size() > 0;
      was_full = mdl.size() == DEPTH;
      if ((pu && was_full && !pop_ok) || (po && mdl.size() == 0)) m_err = 1'b1;
      m_vld = pop_ok;
      if (pop_ok) sb.push_back(mdl.pop_front());
      if (pu && (!was_full || pop_ok)) mdl.push_back(d);
    end
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    reset_L = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_L = '0; umbral_H = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("rst");
    chk("rst.data_out", data_out, 0);
    reset_L = 1'b1;
    @(negedge clk);
    check_all("rel");

    cyc("init26", 1, 0, 0, 0, 2, 6);
    for (int k = 1; k <= 6; k++) cyc("fill6", 0, 1, 0, DATA_WIDTH'(k));
    chk("plan.afull6", almost_full, 1);
    chk("plan.full6", full, 0);
    chk("plan.aempty6", almost_empty, 0);
    cyc("fill7", 0, 1, 0, 6'h07);
    cyc("fill8", 0, 1, 0, 6'h08);
    cyc("ovf", 0, 1, 0, 6'h3F);
    chk("plan.ovf_err", error, 1);
    cyc("pp_full", 0, 1, 1, 6'h2A);
    for (int k = 0; k < 8; k++) cyc("drain", 0, 0, 1, 0);
    cyc("pp_empty", 0, 1, 1, 6'h15);
    cyc("pp_empty+1", 0, 0, 0, 0);
    cyc("pop1", 0, 0, 1, 0);

    for (int k = 0; k <= 20; k++)
      cyc("stagger", 0, k < 20, k > 0, DATA_WIDTH'($urandom_range(0, 63)));

    cyc("init_clamp", 1, 0, 0, 0, 0, 15);
    for (int k = 0; k < 8; k++) cyc("fill_clamp", 0, 1, 0, DATA_WIDTH'(k + 8'h20));
    chk("plan.afull8", almost_full, 1);
    for (int k = 0; k < 3; k++) cyc("pop_to5", 0, 0, 1, 0);

    reset_L = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    reset_L = 1'b1;
    check_all("midrst_rel");
    cyc("pp_empty_r", 0, 1, 1, 6'h11);
    chk("plan.uflow_err", error, 1);
    cyc("push_r", 0, 1, 0, 6'h12);
    for (int k = 0; k < 3; k++) cyc("tail_pop", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
